// File: rtl/e_mdu_ctrl.sv
// E-stage MDU issue/sequencing controller: gates MDU ops, tracks mult/div latency, drives stall.
// Optional feature macro MDU_STALL_CNT_EN adds the 32-bit stall_cnt output and its counter.
module e_mdu_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             e_valid,
  input  logic [3:0]       e_op,
  output logic [3:0]       mdu_op,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [CNT_W-1:0] run_cnt
`ifdef MDU_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;

  logic is_mdu;
  logic is_long;
  logic is_mult;
  logic issue;

  always_comb begin
    is_mdu  = (e_op >= 4'd1) && (e_op <= 4'd8);
    is_long = (e_op >= 4'd1) && (e_op <= 4'd4);
    is_mult = (e_op == 4'd1) || (e_op == 4'd2);
    issue   = e_valid && is_mdu && !req && (state_q == IDLE);
  end

  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    case (state_q)
      IDLE: begin
        if (issue && is_long) begin
          state_d   = RUN;
          run_cnt_d = is_mult ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
        end
      end
      RUN: begin
        // req never cancels a running op: it belongs to an older, committed instruction
        if (run_cnt_q == CNT_W'(1)) begin
          state_d   = IDLE;
          run_cnt_d = '0;
        end else begin
          run_cnt_d = run_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        run_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      run_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  always_comb begin
    mdu_op  = issue ? e_op : 4'd0;
    busy    = (issue && is_long) || (state_q == RUN);
    stall   = e_valid && is_mdu && (state_q == RUN);
    done    = (state_q == RUN) && (run_cnt_q == CNT_W'(1));
    run_cnt = run_cnt_q;
  end

`ifdef MDU_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + (stall ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Testbench for e_mdu_ctrl: directed vectors with literal checks plus a per-cycle reference model.
module tb_e_mdu_ctrl;
  localparam int ML = 5;
  localparam int DL = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req = 1'b0;
  logic       e_valid = 1'b0;
  logic [3:0] e_op = 4'd0;
  logic [3:0] mdu_op;
  logic       busy;
  logic       stall;
  logic       done;
  logic [3:0] run_cnt;
`ifdef MDU_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  e_mdu_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .e_valid  (e_valid),
    .e_op     (e_op),
    .mdu_op   (mdu_op),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .run_cnt  (run_cnt)
`ifdef MDU_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: m_rem = cycles of MDU occupancy remaining after this one started
  int          m_rem = 0;
  int          m_rem_nx = 0;
  logic [31:0] m_stalls = 0;
  logic [31:0] m_stalls_nx = 0;

  always @(negedge clk) begin
    bit mdu, lng, iss, stl;
    if (!reset) begin
      m_rem    = 0;
      m_stalls = 0;
    end
    mdu = (e_op >= 1) && (e_op <= 8);
    lng = (e_op >= 1) && (e_op <= 4);
    iss = e_valid && mdu && !req && (m_rem == 0);
    stl = e_valid && mdu && (m_rem > 0);
    chk("model_mdu_op", mdu_op, iss ? e_op : 4'd0);
    chk("model_busy", busy, (iss && lng) || (m_rem > 0));
    chk("model_stall", stall, stl);
    chk("model_done", done, m_rem == 1);
    chk("model_run_cnt", run_cnt, m_rem);
`ifdef MDU_STALL_CNT_EN
    chk("model_stall_cnt", stall_cnt, m_stalls);
`endif
    if (m_rem > 0)        m_rem_nx = m_rem - 1;
    else if (iss && lng)  m_rem_nx = (e_op <= 2) ? ML : DL;
    else                  m_rem_nx = 0;
    m_stalls_nx = m_stalls + (stl ? 32'd1 : 32'd0);
  end

  always @(posedge clk) begin
    if (reset) begin
      m_rem    = m_rem_nx;
      m_stalls = m_stalls_nx;
    end
  end

  // Present one cycle of E-stage inputs, then wait until outputs are settled past the negedge
  task automatic cyc(input bit v, input logic [3:0] op, input bit r);
    @(posedge clk);
    #1;
    e_valid = v;
    e_op    = op;
    req     = r;
    #5;
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #6;
    chk("rst_run_cnt", run_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_mdu_op", mdu_op, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // two stalled mult-after-mult sequences
    cyc(1, 4'd1, 0);
    chk("mm_issue1", mdu_op, 1);
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < ML; k++) begin
        cyc(1, 4'd1, 0);
        chk("mm_stall", stall, 1);
        chk("mm_hold_op", mdu_op, 0);
      end
      cyc(1, 4'd1, 0);
      chk("mm_reissue", mdu_op, 1);
    end
    repeat (ML) cyc(0, 4'd0, 0);
`ifdef MDU_STALL_CNT_EN
    chk("mm_stall_cnt", stall_cnt, 10);
`endif

    // mult then mflo
    cyc(1, 4'd1, 0);
    chk("mul_op", mdu_op, 1);
    chk("mul_busy", busy, 1);
    chk("mul_stall", stall, 0);
    for (int i = 0; i < ML; i++) begin
      cyc(1, 4'd6, 0);
      chk("mflo_stall", stall, 1);
      chk("mflo_cnt", run_cnt, ML - i);
      chk("mflo_done", done, i == ML - 1);
    end
    cyc(1, 4'd6, 0);
    chk("mflo_issue", mdu_op, 6);
    chk("mflo_busy", busy, 0);
    chk("mflo_nostall", stall, 0);

    // div then divu back-to-back
    cyc(1, 4'd3, 0);
    chk("div_op", mdu_op, 3);
    for (int i = 1; i <= DL; i++) begin
      cyc(1, 4'd4, 0);
      chk("divu_stall", stall, 1);
      chk("divu_held", mdu_op, 0);
      chk("div_done", done, i == DL);
    end
    cyc(1, 4'd4, 0);
    chk("divu_issue", mdu_op, 4);
    chk("divu_busy", busy, 1);
    for (int i = 1; i <= DL; i++) begin
      cyc(0, 4'd0, 0);
      chk("divu_cnt", run_cnt, DL + 1 - i);
      chk("divu_done", done, i == DL);
    end
    cyc(0, 4'd0, 0);
    chk("divu_idle", busy, 0);

    // req blocks issue in IDLE, leaves RUN alone
    cyc(1, 4'd3, 1);
    chk("req_op", mdu_op, 0);
    chk("req_busy", busy, 0);
    cyc(0, 4'd0, 0);
    chk("req_idle_cnt", run_cnt, 0);
    cyc(1, 4'd3, 0);
    chk("req_div_op", mdu_op, 3);
    cyc(1, 4'd3, 1);
    chk("req_run_cnt", run_cnt, 10);
    chk("req_run_stall", stall, 1);
    cyc(0, 4'd0, 1);
    chk("req_run_dec", run_cnt, 9);
    repeat (8) cyc(0, 4'd0, 0);
    chk("req_last_done", done, 1);
    cyc(0, 4'd0, 0);

    // single-cycle ops and unused encodings
    cyc(1, 4'd7, 0);
    chk("mthi_op", mdu_op, 7);
    chk("mthi_busy", busy, 0);
    chk("mthi_stall", stall, 0);
    cyc(1, 4'd12, 0);
    chk("op12_op", mdu_op, 0);
    chk("op12_cnt", run_cnt, 0);
    cyc(0, 4'd1, 0);
    chk("novalid_op", mdu_op, 0);
    chk("novalid_busy", busy, 0);

    // reset in the middle of a div
    cyc(1, 4'd3, 0);
    repeat (4) cyc(0, 4'd0, 0);
    cyc(0, 4'd0, 0);
    chk("mid_cnt6", run_cnt, 6);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_cnt", run_cnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 4'd0, 0);
      chk("mid_no_done", done, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
